register_file: RTL

Architectural register file for the single-cycle MIPS datapath. It sits directly downstream of the JAL destination-register mux: the mux output (rt, rd or the constant 31) drives the write address here, and the two read ports feed the ALU operand path and the store-data path. The block holds 32 × 32-bit registers with one synchronous write port and two combinational read ports. It includes write-to-read bypass and a hardwired-zero `$0`.

---
 rtl/mips_pkg.sv | 10 +
 rtl/register_file.sv | 64 ++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register indices and default widths.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/register_file.sv
// Architectural register file: one synchronous write port, two combinational
// read ports with write-to-read bypass and a hardwired-zero $0.
module register_file
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [DEPTH];

    logic                       w_wr_en;
    logic [1:0][ADDR_W-1:0]     w_raddr;
    logic [1:0][DATA_W-1:0]     w_rdata;

    // Gate on reg_write first so an unknown index with no write is harmless.
    assign w_wr_en = reg_write && (write_reg != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[write_reg] <= write_data;
        end
    end

    assign w_raddr[0] = read_reg1;
    assign w_raddr[1] = read_reg2;

    // Bypass compare runs alongside the array mux; only the final mux is serial.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic              w_zero;
        logic              w_hit;
        logic [DATA_W-1:0] w_arr;

        assign w_arr  = r_regs[w_raddr[p]];
        assign w_zero = (w_raddr[p] == ZERO_IDX);
        assign w_hit  = reg_write && (write_reg == w_raddr[p]) && !w_zero;

        assign w_rdata[p] = reset  ? '0 :
                            w_hit  ? write_data :
                            w_zero ? '0 :
                                     w_arr;
    end

    assign read_data1 = w_rdata[0];
    assign read_data2 = w_rdata[1];

endmodule
